// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: bundles the sequencer's handshake and status signals.
//   run       - level enable from the core controller
//   imem_req  - instruction fetch request        imem_ack - fetch data valid
//   inst_in   - instruction word from memory      inst_out - latched instruction register
//   ex_stall  - execute unit busy                 state    - current sequencer state
//   pc_enable - PC advance strobe                 reg_we   - register-bank write strobe
//   halted    - core stopped                      fault    - sticky fetch-timeout flag
//   retired   - retired-instruction counter
// master: the sequencer. slave: the surrounding core (or a testbench).
interface cpu_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic             run;
   logic             imem_req;
   logic             imem_ack;
   logic [WIDTH-1:0] inst_in;
   logic [WIDTH-1:0] inst_out;
   logic             ex_stall;
   logic [2:0]       state;
   logic             pc_enable;
   logic             reg_we;
   logic             halted;
   logic             fault;
   logic [31:0]      retired;

   modport master (
      input  run, imem_ack, inst_in, ex_stall,
      output imem_req, inst_out, state, pc_enable, reg_we, halted, fault, retired
   );

   modport slave (
      output run, imem_ack, inst_in, ex_stall,
      input  imem_req, inst_out, state, pc_enable, reg_we, halted, fault, retired
   );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITE_BACK control FSM.
// Ports:
//   clk_i  - sole clock, rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - cpu_sequencer_if master modport (handshake, instruction register, strobes,
//            status and retired counter)
// Every output is a register or a direct copy of one; no input reaches an output
// combinationally.
module cpu_sequencer #(
   parameter int unsigned WIDTH   = 32,
   parameter logic [4:0]  HALT_OP = 5'h1F,
   parameter logic [4:0]  BR_OP   = 5'h0C,
   parameter int unsigned TIMEOUT = 16
) (
   input logic             clk_i,
   input logic             rst_ni,
   cpu_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StFetch     = 3'd1,
      StDecode    = 3'd2,
      StExecute   = 3'd3,
      StWriteBack = 3'd4,
      StHalt      = 3'd5
   } state_e;

   // Wait count seen before the final permitted no-ack FETCH edge.
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] inst_q, inst_d;
   logic [7:0]       wait_q, wait_d;
   logic             fault_q, fault_d;
   logic [31:0]      retired_q, retired_d;
   logic             imem_req_q, pc_enable_q, reg_we_q, halted_q;

   always_comb begin
      state_d   = state_q;
      inst_d    = inst_q;
      wait_d    = wait_q;
      fault_d   = fault_q;
      retired_d = retired_q;
      case (state_q)
         StIdle: begin
            if (bus.run) begin
               state_d = StFetch;
               wait_d  = '0;
            end
         end
         StFetch: begin
            if (bus.imem_ack) begin
               inst_d  = bus.inst_in;
               state_d = StDecode;
            end else if (wait_q == TimeoutLast) begin
               state_d = StHalt;
               fault_d = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         StDecode: begin
            state_d = (inst_q[31:27] == HALT_OP) ? StHalt : StExecute;
         end
         StExecute: begin
            if (!bus.ex_stall) state_d = StWriteBack;
         end
         StWriteBack: begin
            retired_d = retired_q + 32'd1;
            if (bus.run) begin
               state_d = StFetch;
               wait_d  = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            // Corrupted state encoding is treated as a fault stop.
            state_d = StHalt;
            fault_d = 1'b1;
         end
      endcase
   end

   // Output flops are loaded from the next state so they line up with state_q.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         inst_q      <= '0;
         wait_q      <= '0;
         fault_q     <= 1'b0;
         retired_q   <= '0;
         imem_req_q  <= 1'b0;
         pc_enable_q <= 1'b0;
         reg_we_q    <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         inst_q      <= inst_d;
         wait_q      <= wait_d;
         fault_q     <= fault_d;
         retired_q   <= retired_d;
         imem_req_q  <= (state_d == StFetch);
         pc_enable_q <= (state_d == StWriteBack);
         reg_we_q    <= (state_d == StWriteBack) && (inst_d[31:27] != BR_OP);
         halted_q    <= (state_d == StHalt);
      end
   end

   assign bus.state     = state_q;
   assign bus.inst_out  = inst_q;
   assign bus.imem_req  = imem_req_q;
   assign bus.pc_enable = pc_enable_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.halted    = halted_q;
   assign bus.fault     = fault_q;
   assign bus.retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed plus randomized bench for cpu_sequencer. A transaction-level
// model tracks the retired count, latched instruction and expected per-cycle phase of
// each instruction from its fetch wait count, stall count and opcode.
module tb_cpu_sequencer;

   localparam logic [4:0]  HALT_OP = 5'h1F;
   localparam logic [4:0]  BR_OP   = 5'h0C;
   localparam int unsigned TIMEOUT = 16;

   logic clk;
   logic rst_n;

   cpu_sequencer_if #(.WIDTH(32)) bus ();

   cpu_sequencer #(
      .WIDTH   (32),
      .HALT_OP (HALT_OP),
      .BR_OP   (BR_OP),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [31:0] m_retired = '0;
   logic [31:0] m_inst    = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_inst", bus.inst_out, 32'd0);
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_pc", 32'(bus.pc_enable), 32'd0);
      chk("rst_we", 32'(bus.reg_we), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_fault", 32'(bus.fault), 32'd0);
      chk("rst_retired", bus.retired, 32'd0);
   endtask

   // Reset asserted between clock edges; outputs must respond without a clock edge.
   task automatic async_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      m_retired = '0;
      m_inst    = '0;
      chk_reset_vals();
      bus.run = 1'b0;
      bus.imem_ack = 1'b0;
      bus.ex_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // From IDLE: FETCH is reached one cycle after run is sampled.
   task automatic start_run();
      bus.run = 1'b1;
      @(negedge clk);
      chk("start_state", 32'(bus.state), 32'd1);
      chk("start_req", 32'(bus.imem_req), 32'd1);
   endtask

   // Starts with the DUT in FETCH; ends in FETCH (run_after=1), IDLE, or HALT.
   task automatic do_instr(input logic [31:0] inst, input int waits, input int stalls,
                           input bit run_after);
      logic [4:0] op;
      op = inst[31:27];
      for (int w = 0; w < waits; w++) begin
         bus.imem_ack = 1'b0;
         @(negedge clk);
         chk("fetch_wait_state", 32'(bus.state), 32'd1);
         chk("fetch_wait_req", 32'(bus.imem_req), 32'd1);
      end
      bus.imem_ack = 1'b1;
      bus.inst_in  = inst;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.inst_in  = $urandom;
      bus.ex_stall = 1'($urandom);
      m_inst = inst;
      chk("decode_state", 32'(bus.state), 32'd2);
      chk("decode_inst", bus.inst_out, m_inst);
      chk("decode_req", 32'(bus.imem_req), 32'd0);
      chk("decode_fault", 32'(bus.fault), 32'd0);
      if (op == HALT_OP) begin
         @(negedge clk);
         chk("halt_state", 32'(bus.state), 32'd5);
         chk("halt_halted", 32'(bus.halted), 32'd1);
         chk("halt_retired", bus.retired, m_retired);
         chk("halt_pc", 32'(bus.pc_enable), 32'd0);
         return;
      end
      @(negedge clk);
      chk("exec_state", 32'(bus.state), 32'd3);
      for (int s = 0; s < stalls; s++) begin
         bus.ex_stall = 1'b1;
         bus.imem_ack = 1'($urandom);  // ignored outside FETCH
         bus.inst_in  = $urandom;
         @(negedge clk);
         chk("stall_state", 32'(bus.state), 32'd3);
         chk("stall_inst", bus.inst_out, m_inst);
         chk("stall_pc", 32'(bus.pc_enable), 32'd0);
      end
      bus.ex_stall = 1'b0;
      bus.imem_ack = 1'b0;
      bus.run      = run_after;
      @(negedge clk);
      chk("wb_state", 32'(bus.state), 32'd4);
      chk("wb_pc", 32'(bus.pc_enable), 32'd1);
      chk("wb_we", 32'(bus.reg_we), (op != BR_OP) ? 32'd1 : 32'd0);
      chk("wb_retired", bus.retired, m_retired);
      chk("wb_inst", bus.inst_out, m_inst);
      @(negedge clk);
      m_retired = m_retired + 32'd1;
      chk("post_wb_retired", bus.retired, m_retired);
      chk("post_wb_state", 32'(bus.state), run_after ? 32'd1 : 32'd0);
      chk("post_wb_pc", 32'(bus.pc_enable), 32'd0);
      chk("post_wb_we", 32'(bus.reg_we), 32'd0);
      chk("post_wb_req", 32'(bus.imem_req), run_after ? 32'd1 : 32'd0);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [4:0] op;
      logic [26:0] lo;
      op = ($urandom_range(0, 3) == 0) ? BR_OP : 5'($urandom_range(0, 30));
      lo = 27'($urandom);
      return {op, lo};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      bus.run      = 1'b0;
      bus.imem_ack = 1'b0;
      bus.inst_in  = '0;
      bus.ex_stall = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_vals();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.imem_ack = 1'($urandom);
         bus.inst_in  = $urandom;
         @(negedge clk);
         chk("idle_state", 32'(bus.state), 32'd0);
         chk("idle_inst", bus.inst_out, 32'd0);
         chk("idle_pc", 32'(bus.pc_enable), 32'd0);
      end
      bus.imem_ack = 1'b0;

      // Straight-line run of three non-branch instructions.
      start_run();
      do_instr(32'h0800_1234, 0, 0, 1'b1);
      do_instr(32'h10AB_CDEF, 0, 0, 1'b1);
      do_instr(32'h2800_FFFF, 0, 0, 1'b0);
      chk("straight_retired", bus.retired, 32'd3);

      // Branch with a five-cycle stall.
      start_run();
      do_instr({BR_OP, 27'h123_4567}, 0, 5, 1'b1);

      // Ack on the last permitted FETCH edge is still accepted.
      do_instr(32'h1800_0042, int'(TIMEOUT) - 1, 0, 1'b1);

      // Randomized instruction stream.
      for (int n = 0; n < 20; n++) begin
         bit ra;
         ra = (n == 19) ? 1'b1 : 1'($urandom);
         do_instr(rand_inst(), $urandom_range(0, 4), $urandom_range(0, 3), ra);
         if (!ra) begin
            int idle_n;
            idle_n = $urandom_range(0, 2);
            for (int k = 0; k < idle_n; k++) begin
               @(negedge clk);
               chk("rand_idle_state", 32'(bus.state), 32'd0);
            end
            start_run();
         end
      end

      // Fetch timeout: no ack for TIMEOUT edges.
      bus.imem_ack = 1'b0;
      for (int w = 0; w < int'(TIMEOUT) - 1; w++) begin
         @(negedge clk);
         chk("to_wait_state", 32'(bus.state), 32'd1);
      end
      @(negedge clk);
      chk("to_state", 32'(bus.state), 32'd5);
      chk("to_halted", 32'(bus.halted), 32'd1);
      chk("to_fault", 32'(bus.fault), 32'd1);
      chk("to_req", 32'(bus.imem_req), 32'd0);
      for (int i = 0; i < 20; i++) begin
         bus.run      = 1'($urandom);
         bus.imem_ack = 1'($urandom);
         bus.inst_in  = $urandom;
         @(negedge clk);
         chk("to_hold_state", 32'(bus.state), 32'd5);
         chk("to_hold_retired", bus.retired, m_retired);
         chk("to_hold_pc", 32'(bus.pc_enable), 32'd0);
      end
      bus.imem_ack = 1'b0;
      async_reset();

      // HALT opcode then recovery through reset.
      start_run();
      do_instr(32'hF800_0000, 0, 0, 1'b1);
      chk("halt_op_fault", 32'(bus.fault), 32'd0);
      async_reset();

      // run dropped in EXECUTE: instruction retires then IDLE.
      start_run();
      do_instr(32'h2000_0077, 1, 2, 1'b0);
      chk("drop_retired", bus.retired, 32'd1);

      // Reset pulsed mid-FETCH.
      start_run();
      bus.imem_ack = 1'b0;
      @(negedge clk);
      chk("midfetch_state", 32'(bus.state), 32'd1);
      async_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
